// File: rtl/mem_addr_seq.sv
// -----------------------------------------------------------------------------
// mem_addr_seq
//
// Memory-address source select and fixed-latency access sequencer. On an
// accepted start the selected source is registered onto addr_out and checked
// for alignment against the access size. An aligned request runs a LATENCY-cycle
// memory access (byte lanes and write strobe driven), followed by a one-cycle
// done pulse. A misaligned request produces a one-cycle misalign pulse and no
// memory access.
//
// Ports:
//   clk       in   single clock, rising edge
//   reset     in   synchronous active-high reset
//   sel       in   [SELW]        address source index, sampled with start
//   src       in   [NSRC*WIDTH]  flattened sources, source i = src[i*WIDTH +: WIDTH]
//   size      in   [2]           00 word, 01 half, 10 byte, 11 reserved
//   wr        in   access is a write, sampled with start
//   start     in   request an access, accepted only when idle
//   busy      out  access in progress (ACCESS or DONE)
//   done      out  one-cycle completion pulse
//   misalign  out  one-cycle rejection pulse
//   addr_out  out  [WIDTH]       registered selected address
//   byte_en   out  [4]           byte lanes, active during ACCESS
//   mem_wr    out  memory write strobe, active during ACCESS
// -----------------------------------------------------------------------------
module mem_addr_seq #(
   parameter int WIDTH   = 32,
   parameter int NSRC    = 4,
   parameter int SELW    = $clog2(NSRC),
   parameter int LATENCY = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [SELW-1:0]       sel,
   input  logic [NSRC*WIDTH-1:0] src,
   input  logic [1:0]            size,
   input  logic                  wr,
   input  logic                  start,
   output logic                  busy,
   output logic                  done,
   output logic                  misalign,
   output logic [WIDTH-1:0]      addr_out,
   output logic [3:0]            byte_en,
   output logic                  mem_wr
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2,
      ERR    = 2'd3
   } state_t;

   // Counter reload: the counter runs LATENCY-1 down to 0, one ACCESS cycle each.
   localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

   state_t           state_r;
   logic [3:0]       cnt_r;
   logic [SELW-1:0]  sel_idx_s;
   logic [WIDTH-1:0] src_arr_s [NSRC];
   logic [WIDTH-1:0] sel_addr_s;
   logic             misaligned_s;
   logic [3:0]       lanes_s;

   // Alignment rule for a given low address pair and access size.
   function automatic logic is_misaligned(input logic [1:0] low, input logic [1:0] sz);
      logic bad;
      case (sz)
         2'b00:   bad = (low != 2'b00);
         2'b01:   bad = low[0];
         2'b10:   bad = 1'b0;
         default: bad = 1'b1;   // reserved size is never a legal access
      endcase
      return bad;
   endfunction

   // Byte-lane mask for a given low address pair and access size.
   function automatic logic [3:0] lane_mask(input logic [1:0] low, input logic [1:0] sz);
      logic [3:0] m;
      case (sz)
         2'b00:   m = 4'b1111;
         2'b01:   m = low[1] ? 4'b1100 : 4'b0011;
         2'b10:   m = 4'b0001 << low;
         default: m = 4'b0000;
      endcase
      return m;
   endfunction

   // Unflatten the source bus into an indexable array.
   for (genvar i = 0; i < NSRC; i++) begin : g_src
      assign src_arr_s[i] = src[i*WIDTH +: WIDTH];
   end

   // Out-of-range selects fall back to source 0; only needed when NSRC is not a power of two.
   if ((1 << SELW) == NSRC) begin : g_sel_full
      assign sel_idx_s = sel;
   end else begin : g_sel_clamp
      assign sel_idx_s = (int'(sel) < NSRC) ? sel : {SELW{1'b0}};
   end

   // Selected address and its alignment/lane decode, consumed only on an accepted start.
   always_comb begin
      sel_addr_s   = src_arr_s[sel_idx_s];
      misaligned_s = is_misaligned(sel_addr_s[1:0], size);
      lanes_s      = lane_mask(sel_addr_s[1:0], size);
   end

   // Access sequencer: state, latency counter and all registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r  <= IDLE;
         cnt_r    <= 4'd0;
         addr_out <= {WIDTH{1'b0}};
         byte_en  <= 4'b0000;
         mem_wr   <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         misalign <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (start) begin
                  // Address is latched even for a rejected request and held until the next start.
                  addr_out <= sel_addr_s;
                  if (misaligned_s) begin
                     state_r  <= ERR;
                     misalign <= 1'b1;
                  end else begin
                     state_r <= ACCESS;
                     cnt_r   <= CNT_LOAD;
                     busy    <= 1'b1;
                     byte_en <= lanes_s;
                     mem_wr  <= wr;
                  end
               end
            end
            ACCESS: begin
               if (cnt_r == 4'd0) begin
                  state_r <= DONE;
                  byte_en <= 4'b0000;
                  mem_wr  <= 1'b0;
                  done    <= 1'b1;
               end else begin
                  cnt_r <= cnt_r - 4'd1;
               end
            end
            DONE: begin
               state_r <= IDLE;
               done    <= 1'b0;
               busy    <= 1'b0;
            end
            ERR: begin
               state_r  <= IDLE;
               misalign <= 1'b0;
            end
            default: begin
               state_r  <= IDLE;
               cnt_r    <= 4'd0;
               byte_en  <= 4'b0000;
               mem_wr   <= 1'b0;
               busy     <= 1'b0;
               done     <= 1'b0;
               misalign <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_addr_seq.sv
// -----------------------------------------------------------------------------
// tb_mem_addr_seq
//
// Two instances: d1 with LATENCY=1 and d3 with LATENCY=3. Stimulus pushes the
// expected response of each request into a queue; a negedge monitor pops an
// entry whenever an instance pulses done or misalign and compares address,
// lanes, write strobe, ACCESS length and completion cycle.
// -----------------------------------------------------------------------------
module tb_mem_addr_seq;

   localparam int W = 32;

   typedef struct {
      int         id;
      logic       is_err;
      logic [31:0] addr;
      logic [3:0] be;
      logic       wr;
      int         ncyc;
      int         at_cyc;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic          reset1, start1, wr1, busy1, done1, mis1, mw1;
   logic [1:0]    sel1, size1;
   logic [4*W-1:0] src1;
   logic [W-1:0]  addr1;
   logic [3:0]    be1;

   logic          reset3, start3, wr3, busy3, done3, mis3, mw3;
   logic [1:0]    sel3, size3;
   logic [4*W-1:0] src3;
   logic [W-1:0]  addr3;
   logic [3:0]    be3;

   mem_addr_seq #(.WIDTH(W), .NSRC(4), .LATENCY(1)) d1 (
      .clk(clk), .reset(reset1), .sel(sel1), .src(src1), .size(size1), .wr(wr1),
      .start(start1), .busy(busy1), .done(done1), .misalign(mis1),
      .addr_out(addr1), .byte_en(be1), .mem_wr(mw1)
   );

   mem_addr_seq #(.WIDTH(W), .NSRC(4), .LATENCY(3)) d3 (
      .clk(clk), .reset(reset3), .sel(sel3), .src(src3), .size(size3), .wr(wr3),
      .start(start3), .busy(busy3), .done(done3), .misalign(mis3),
      .addr_out(addr3), .byte_en(be3), .mem_wr(mw3)
   );

   exp_t q[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   int         acc_cnt [4];
   logic [3:0] acc_be  [4];
   logic       acc_wr  [4];
   logic       acc_ok  [4];
   logic       leak    [4];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
      n_checks++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, expv);
      end
   endtask

   // Per-cycle bookkeeping for one instance; compares against the queue on done/misalign.
   task automatic observe(input int id, input logic busy, input logic dn, input logic mis,
                          input logic [31:0] a, input logic [3:0] be, input logic w);
      exp_t e;
      if (!busy || dn) begin
         if (be != 4'b0000 || w) leak[id] = 1'b1;
      end
      if (busy && !dn) begin
         if (acc_cnt[id] == 0) begin
            acc_be[id] = be;
            acc_wr[id] = w;
         end else if (be != acc_be[id] || w != acc_wr[id]) begin
            acc_ok[id] = 1'b0;
         end
         acc_cnt[id]++;
      end
      if (dn || mis) begin
         if (q.size() == 0) begin
            check($sformatf("d%0d_unexpected_event", id), 64'd1, 64'd0);
         end else begin
            e = q.pop_front();
            check($sformatf("d%0d_id", id), 64'(id), 64'(e.id));
            check($sformatf("d%0d_kind", id), {63'd0, mis}, {63'd0, e.is_err});
            check($sformatf("d%0d_addr", id), {32'd0, a}, {32'd0, e.addr});
            check($sformatf("d%0d_cycle", id), 64'(cyc), 64'(e.at_cyc));
            check($sformatf("d%0d_idle_lanes", id), {63'd0, leak[id]}, 64'd0);
            if (dn) begin
               check($sformatf("d%0d_byte_en", id), {60'd0, acc_be[id]}, {60'd0, e.be});
               check($sformatf("d%0d_mem_wr", id), {63'd0, acc_wr[id]}, {63'd0, e.wr});
               check($sformatf("d%0d_access_len", id), 64'(acc_cnt[id]), 64'(e.ncyc));
               check($sformatf("d%0d_steady", id), {63'd0, acc_ok[id]}, 64'd1);
            end else begin
               check($sformatf("d%0d_err_busy", id), {63'd0, busy}, 64'd0);
            end
         end
         leak[id] = 1'b0;
      end
      if (!busy) begin
         acc_cnt[id] = 0;
         acc_ok[id]  = 1'b1;
      end
   endtask

   // Monitor: sample both instances away from the active edge.
   always @(negedge clk) begin
      observe(1, busy1, done1, mis1, addr1, be1, mw1);
      observe(3, busy3, done3, mis3, addr3, be3, mw3);
   end

   task automatic set_src(input int id, input int i, input logic [31:0] v);
      if (id == 1) src1[i*W +: W] = v;
      else         src3[i*W +: W] = v;
   endtask

   // Wait (bounded) until every queued response has been seen, then settle into IDLE.
   task automatic drain();
      int n = 0;
      while (q.size() != 0 && n < 20) begin
         @(posedge clk);
         n++;
      end
      check("drain", 64'(q.size()), 64'd0);
      if (q.size() != 0) q.delete();
      @(negedge clk);
   endtask

   task automatic issue(input int id, input logic [1:0] s, input logic [1:0] sz, input logic w,
                        input logic is_err, input logic [31:0] a, input logic [3:0] be);
      exp_t e;
      int   lat;
      lat      = (id == 1) ? 1 : 3;
      e.id     = id;
      e.is_err = is_err;
      e.addr   = a;
      e.be     = be;
      e.wr     = w;
      e.ncyc   = lat;
      e.at_cyc = cyc + 1 + (is_err ? 0 : lat);
      q.push_back(e);
      if (id == 1) begin
         sel1 = s; size1 = sz; wr1 = w; start1 = 1'b1;
      end else begin
         sel3 = s; size3 = sz; wr3 = w; start3 = 1'b1;
      end
      @(negedge clk);
      start1 = 1'b0;
      start3 = 1'b0;
      drain();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: actual timeout required finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      exp_t e;
      for (int i = 0; i < 4; i++) begin
         acc_cnt[i] = 0; acc_be[i] = 4'd0; acc_wr[i] = 1'b0; acc_ok[i] = 1'b1; leak[i] = 1'b0;
      end
      reset1 = 1'b1; reset3 = 1'b1; start1 = 1'b1; start3 = 1'b1;
      sel1 = 2'd0; size1 = 2'd0; wr1 = 1'b0; src1 = '0;
      sel3 = 2'd0; size3 = 2'd0; wr3 = 1'b0; src3 = '0;

      // Reset held with start high: everything stays zero.
      repeat (2) begin
         @(negedge clk);
         check("reset_d1", {27'd0, busy1, done1, mis1, mw1, be1, addr1}, 64'd0);
         check("reset_d3", {27'd0, busy3, done3, mis3, mw3, be3, addr3}, 64'd0);
      end
      reset1 = 1'b0; reset3 = 1'b0; start1 = 1'b0; start3 = 1'b0;

      // Word reads through each source.
      set_src(1, 0, 32'h100); set_src(1, 1, 32'h204); set_src(1, 2, 32'h308); set_src(1, 3, 32'h40C);
      for (int i = 0; i < 4; i++)
         issue(1, 2'(i), 2'b00, 1'b0, 1'b0, 32'h100 + i * 32'h104, 4'b1111);
      check("addr_hold_after_done", {32'd0, addr1}, 64'h40C);

      // Byte/half lanes and rejections.
      set_src(1, 0, 32'h3); set_src(1, 1, 32'h2); set_src(1, 2, 32'h1); set_src(1, 3, 32'h6);
      issue(1, 2'd0, 2'b10, 1'b0, 1'b0, 32'h3, 4'b1000);
      issue(1, 2'd1, 2'b01, 1'b0, 1'b0, 32'h2, 4'b1100);
      issue(1, 2'd2, 2'b01, 1'b0, 1'b1, 32'h1, 4'b0000);
      check("addr_hold_after_err", {32'd0, addr1}, 64'h1);
      issue(1, 2'd3, 2'b10, 1'b0, 1'b0, 32'h6, 4'b0100);
      issue(1, 2'd1, 2'b00, 1'b0, 1'b1, 32'h2, 4'b0000);
      issue(1, 2'd0, 2'b11, 1'b0, 1'b1, 32'h3, 4'b0000);
      set_src(1, 3, 32'h104);
      issue(1, 2'd3, 2'b01, 1'b1, 1'b0, 32'h104, 4'b0011);
      issue(1, 2'd3, 2'b10, 1'b0, 1'b0, 32'h104, 4'b0001);

      // Write with LATENCY=3; second start and source changes during ACCESS are ignored.
      set_src(3, 2, 32'h10);
      sel3 = 2'd2; size3 = 2'b00; wr3 = 1'b1; start3 = 1'b1;
      e.id = 3; e.is_err = 1'b0; e.addr = 32'h10; e.be = 4'b1111; e.wr = 1'b1;
      e.ncyc = 3; e.at_cyc = cyc + 4;
      q.push_back(e);
      @(negedge clk);
      start3 = 1'b0;
      check("wr_addr", {32'd0, addr3}, 64'h10);
      check("wr_lanes", {58'd0, busy3, mw3, be3}, {58'd0, 6'b111111});
      @(negedge clk);
      check("wr_hold_a", {32'd0, addr3}, 64'h10);
      sel3 = 2'd0; set_src(3, 0, 32'h44); set_src(3, 2, 32'h88); size3 = 2'b11; start3 = 1'b1;
      @(negedge clk);
      start3 = 1'b0; size3 = 2'b00;
      check("wr_hold_b", {32'd0, addr3}, 64'h10);
      check("wr_busy", {63'd0, busy3}, 64'd1);
      drain();

      // Reserved size at an aligned address.
      set_src(3, 1, 32'h100);
      issue(3, 2'd1, 2'b11, 1'b0, 1'b1, 32'h100, 4'b0000);

      // Abort in the second ACCESS cycle: no done afterwards.
      sel3 = 2'd2; size3 = 2'b00; wr3 = 1'b1; start3 = 1'b1;
      @(negedge clk);
      start3 = 1'b0;
      @(negedge clk);
      check("abort_pre", {62'd0, busy3, mw3}, 64'd3);
      reset3 = 1'b1;
      @(negedge clk);
      check("abort", {27'd0, busy3, done3, mis3, mw3, be3, addr3}, 64'd0);
      reset3 = 1'b0;
      repeat (8) @(negedge clk);
      check("abort_quiet", {27'd0, busy3, done3, mis3, mw3, be3, addr3}, 64'd0);

      check("leak_d1", {63'd0, leak[1]}, 64'd0);
      check("leak_d3", {63'd0, leak[3]}, 64'd0);
      check("queue_empty", 64'(q.size()), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_addr_seq.md
# mem_addr_seq

Parametrised successor to the CPU's memory-address source select. It picks one of `NSRC` address sources (PC, ALU result, ALUOut, and others), registers the result, and checks alignment against the access size. It then sequences a fixed-latency memory access with a start/done handshake and drives the memory's address, byte enables and write strobe. It sits between the multicycle control unit and the instruction/data memory.

## Interface
- `WIDTH`, 32: address width in bits (≥ 2).
- `NSRC`, 4: number of address sources (≥ 2).
- `SELW`, `$clog2(NSRC)`: select width.
- `LATENCY`, 1: memory access cycles, 1..15.

- `clk`  in  1  single clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `sel`  in  `SELW`  address source index. Sampled with `start`.
- `src`  in  `NSRC*WIDTH`  flattened sources; source i is `src[i*WIDTH +: WIDTH]`.
- `size`  in  2  access size: 00 word, 01 half, 10 byte, 11 reserved. Sampled with `start`.
- `wr`  in  1  access is a write. Sampled with `start`.
- `start`  in  1  request an access; accepted only in IDLE.
- `busy`  out  1  an access is in progress (ACCESS or DONE).
- `done`  out  1  one-cycle pulse when the access completes.
- `misalign`  out  1  one-cycle pulse when a request is rejected.
- `addr_out`  out  `WIDTH`  registered selected address.
- `byte_en`  out  4  byte lanes, active during ACCESS.
- `mem_wr`  out  1  memory write strobe.

## Operation
- FSM states: IDLE, ACCESS, DONE, ERR.
- **IDLE, `start`=0:** stay in IDLE.
- **IDLE, `start`=1:** latch `addr_out` ← selected source. `sel` ≥ `NSRC` selects source 0. Then evaluate alignment:
  - Misaligned when `size`=00 and `addr[1:0]`≠0.
  - Misaligned when `size`=01 and `addr[0]`=1.
  - Always misaligned when `size`=11.
  - Misaligned → ERR. Aligned → ACCESS, load counter with `LATENCY`-1, latch `wr`.
- **ACCESS:**
  - `byte_en` by size: word = 1111; half = 0011 if `addr[1]`=0, else 1100; byte = 0001 << `addr[1:0]`.
  - `mem_wr` = latched `wr`.
  - Counter decrements each cycle; at 0 → DONE.
- **DONE:** `done`=1, `byte_en`=0, `mem_wr`=0. Next state IDLE.
- **ERR:** `misalign`=1. `byte_en` and `mem_wr` stay 0; no memory access occurs. Next state IDLE.
- `start` in any state other than IDLE is ignored; no queueing.
- `addr_out` holds its value until the next accepted `start`, including after ERR.
- Changes on `src` or `sel` after acceptance do not affect the access in progress.

## Timing
- **Reset values:** state IDLE; `addr_out`=0, `byte_en`=0, `mem_wr`=0, `busy`=0, `done`=0, `misalign`=0, counter=0.
- **Reset mid-operation:** abort immediately the next edge. No `done` or `misalign` pulse is emitted.
- **Accepted `start` at edge T:**
  - `addr_out` valid after T.
  - `busy`=1, `byte_en`/`mem_wr` active for cycles T+1 .. T+`LATENCY`.
  - `done`=1 in cycle T+`LATENCY`+1.
  - IDLE again, able to accept `start`, in cycle T+`LATENCY`+2.
- **Rejected `start` at T:** `misalign`=1 in cycle T+1 only; `busy` stays 0; IDLE at T+2.
- **Throughput:** one access per `LATENCY`+2 cycles.
- **Simultaneous events:** `reset` and `start` together → `reset` wins. `start` held high → a new request is accepted on each return to IDLE.

## Test plan
- **Reset:** drive `reset` 2 cycles with `start`=1 → all outputs 0, state IDLE throughout.
- **Source select, word read:** `LATENCY`=1; sources 0x100, 0x204, 0x308, 0x40C; for each `sel` 0..3, pulse `start` with `size`=00, `wr`=0:
  - `addr_out` = chosen source.
  - `byte_en`=1111 for 1 cycle, `mem_wr`=0.
  - `done` 2 cycles after `start`.
- **Byte/half lanes:**
  - Address 0x3 with `size`=10 → `byte_en`=1000.
  - Address 0x2 with `size`=01 → `byte_en`=1100.
  - Address 0x1 with `size`=01 → `misalign` pulse, `byte_en` stays 0000, `busy` never rises.
- **Write with latency:** `LATENCY`=3, `wr`=1, address 0x10 → `mem_wr`=1 and `byte_en`=1111 for exactly 3 cycles, `done` at T+4. A second `start` at T+2 is ignored.
- **Source stability:** change `src` and `sel` during ACCESS → `addr_out` unchanged. `size`=11 at any address → `misalign`.
- **Abort:** assert `reset` in the 2nd ACCESS cycle (`LATENCY`=3) → next cycle `busy`=0, `mem_wr`=0, `addr_out`=0; no `done` pulse follows.
